// File: rtl/counter_monitor_pkg.sv
// Shared types, default parameters and the step-legality helper for the
// counter_monitor receive-side checker.
package counter_monitor_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    FAULT    = 2'd2
  } mon_state_e;

  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_CNT_WIDTH   = 8;
  localparam int unsigned DEF_LOCK_CYCLES = 4;

  // True when cur equals prev or prev+1, both taken modulo 2^width (width <= 32).
  function automatic logic is_legal_step(input logic [31:0] prev,
                                         input logic [31:0] cur,
                                         input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32'd32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return ((cur & mask) == (prev & mask)) ||
           ((cur & mask) == ((prev + 32'd1) & mask));
  endfunction

endpackage

// File: rtl/counter_monitor_sat_counter.sv
// Statistic counter with increment, synchronous clear (dominant) and an
// optional saturate-at-max mode; otherwise wraps modulo 2^CNT_WIDTH.
module monitor_sat_counter #(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 clear,
  input  logic                 sat_en,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] count_r;
  logic [CNT_WIDTH-1:0] count_n_s;

  // Next count: clear beats increment, saturation holds at max when enabled.
  always_comb begin
    count_n_s = count_r;
    if (clear) begin
      count_n_s = {CNT_WIDTH{1'b0}};
    end else if (inc) begin
      if (sat_en && (count_r == CNT_MAX)) begin
        count_n_s = count_r;
      end else begin
        count_n_s = count_r + CNT_ONE;
      end
    end else begin
      count_n_s = count_r;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {CNT_WIDTH{1'b0}};
    end else begin
      count_r <= count_n_s;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/counter_monitor.sv
// Checks that an observed counter holds or steps by one and that its flag
// equals (state == 0) | cond1; tracks lock, wraps and error statistics.
module counter_monitor
  import counter_monitor_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int unsigned LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     io_state,
  input  logic                 io_flag,
  input  logic                 io_cond1,
  input  logic                 io_clear,
  output logic                 io_locked,
  output logic                 io_error,
  output logic [CNT_WIDTH-1:0] io_errorCount,
  output logic [CNT_WIDTH-1:0] io_wrapCount
);

  localparam int unsigned RUN_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_TARGET = RUN_W'(LOCK_CYCLES);
  localparam logic [RUN_W-1:0] RUN_ONE    = RUN_W'(1);

  mon_state_e        state_r;
  mon_state_e        state_n_s;
  logic [WIDTH-1:0]  prev_state_r;
  logic              prev_valid_r;
  logic [RUN_W-1:0]  run_cnt_r;
  logic [RUN_W-1:0]  run_cnt_n_s;
  logic              locked_r;
  logic              error_r;

  logic              flag_ok_s;
  logic              step_ok_s;
  logic              legal_s;
  logic              wrap_seen_s;
  logic              err_inc_s;
  logic              wrap_inc_s;

  // Legality of the current sample against the previous one.
  always_comb begin
    flag_ok_s   = (io_flag == ((io_state == {WIDTH{1'b0}}) | io_cond1));
    step_ok_s   = is_legal_step(32'(prev_state_r), 32'(io_state), WIDTH);
    legal_s     = flag_ok_s & (~prev_valid_r | step_ok_s);
    wrap_seen_s = prev_valid_r & (prev_state_r == {WIDTH{1'b1}}) &
                  (io_state == {WIDTH{1'b0}});
  end

  // Lock FSM next state, run counter and statistic increments.
  always_comb begin
    state_n_s   = state_r;
    run_cnt_n_s = run_cnt_r;
    err_inc_s   = 1'b0;
    wrap_inc_s  = 1'b0;
    case (state_r)
      UNLOCKED: begin
        if (legal_s) begin
          if ((run_cnt_r + RUN_ONE) == RUN_TARGET) begin
            state_n_s   = LOCKED;
            run_cnt_n_s = {RUN_W{1'b0}};
          end else begin
            run_cnt_n_s = run_cnt_r + RUN_ONE;
          end
        end else begin
          run_cnt_n_s = {RUN_W{1'b0}};
        end
      end
      LOCKED: begin
        if (legal_s) begin
          wrap_inc_s = wrap_seen_s;
        end else begin
          state_n_s = FAULT;
          err_inc_s = 1'b1;
        end
      end
      FAULT: begin
        // The sample seen here only refreshes prev_state_r.
        state_n_s   = UNLOCKED;
        run_cnt_n_s = {RUN_W{1'b0}};
      end
      default: begin
        state_n_s   = UNLOCKED;
        run_cnt_n_s = {RUN_W{1'b0}};
      end
    endcase
  end

  // FSM, history and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= UNLOCKED;
      prev_state_r <= {WIDTH{1'b0}};
      prev_valid_r <= 1'b0;
      run_cnt_r    <= {RUN_W{1'b0}};
      locked_r     <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      state_r      <= state_n_s;
      prev_state_r <= io_state;
      prev_valid_r <= 1'b1;
      run_cnt_r    <= run_cnt_n_s;
      locked_r     <= (state_n_s == LOCKED);
      error_r      <= err_inc_s;
    end
  end

  monitor_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_err_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (err_inc_s),
    .clear  (io_clear),
    .sat_en (1'b1),
    .count  (io_errorCount)
  );

  monitor_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_wrap_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (wrap_inc_s),
    .clear  (io_clear),
    .sat_en (1'b0),
    .count  (io_wrapCount)
  );

  assign io_locked = locked_r;
  assign io_error  = error_r;

endmodule

// File: tb/tb_counter_monitor.sv
// Directed self-checking bench for counter_monitor with hand-computed expectations.
module tb_counter_monitor;

  logic       clk;
  logic       reset;
  logic [7:0] io_state;
  logic       io_flag;
  logic       io_cond1;
  logic       io_clear;
  logic       io_locked;
  logic       io_error;
  logic [7:0] io_errorCount;
  logic [7:0] io_wrapCount;

  int checks;
  int errors;

  counter_monitor #(.WIDTH(8), .CNT_WIDTH(8), .LOCK_CYCLES(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .io_state      (io_state),
    .io_flag       (io_flag),
    .io_cond1      (io_cond1),
    .io_clear      (io_clear),
    .io_locked     (io_locked),
    .io_error      (io_error),
    .io_errorCount (io_errorCount),
    .io_wrapCount  (io_wrapCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // One sample: inputs applied just after an edge, outputs checked 1 after the next edge.
  task automatic drive(input logic [7:0] s, input logic f, input logic c, input logic clr);
    io_state = s;
    io_flag  = f;
    io_cond1 = c;
    io_clear = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic good(input logic [7:0] s);
    drive(s, (s == 8'd0), 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    io_state = 8'd0; io_flag = 1'b1; io_cond1 = 1'b0; io_clear = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic relock(input logic [7:0] s);
    for (int i = 0; i < 4; i++) good(s);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    io_state = 8'd0; io_flag = 1'b1; io_cond1 = 1'b0; io_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (io_locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b expected 0", io_locked); end
    checks++; if (io_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %0b expected 0", io_error); end
    checks++; if (io_errorCount !== 8'd0) begin errors++; $display("FAIL reset_errcnt: got %0d expected 0", io_errorCount); end
    checks++; if (io_wrapCount !== 8'd0) begin errors++; $display("FAIL reset_wrapcnt: got %0d expected 0", io_wrapCount); end
    reset = 1'b0;
  endtask

  task automatic test_lock();
    for (int i = 1; i <= 4; i++) begin
      good(8'd0);
      checks++;
      if (io_locked !== (i == 4)) begin
        errors++; $display("FAIL lock_rise sample %0d: got %0b expected %0b", i, io_locked, (i == 4));
      end
    end
    checks++; if (io_errorCount !== 8'd0) begin errors++; $display("FAIL lock_errcnt: got %0d expected 0", io_errorCount); end
  endtask

  task automatic test_wrap();
    logic [7:0] seq [5];
    logic [7:0] exp_wrap [5];
    seq = '{8'd253, 8'd254, 8'd255, 8'd0, 8'd1};
    exp_wrap = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1};
    do_reset();
    relock(8'd253);
    checks++; if (io_locked !== 1'b1) begin errors++; $display("FAIL wrap_locked: got %0b expected 1", io_locked); end
    for (int i = 0; i < 5; i++) begin
      good(seq[i]);
      checks++;
      if (io_wrapCount !== exp_wrap[i]) begin
        errors++; $display("FAIL wrap_count at %0d: got %0d expected %0d", seq[i], io_wrapCount, exp_wrap[i]);
      end
      checks++;
      if (io_error !== 1'b0) begin errors++; $display("FAIL wrap_noerr at %0d: got %0b expected 0", seq[i], io_error); end
    end
  endtask

  task automatic test_step_error();
    logic [7:0] relock_seq [5];
    relock_seq = '{8'd12, 8'd12, 8'd13, 8'd14, 8'd15};
    do_reset();
    relock(8'd10);
    good(8'd12);
    checks++; if (io_error !== 1'b1) begin errors++; $display("FAIL step_err_pulse: got %0b expected 1", io_error); end
    checks++; if (io_errorCount !== 8'd1) begin errors++; $display("FAIL step_errcnt: got %0d expected 1", io_errorCount); end
    checks++; if (io_locked !== 1'b0) begin errors++; $display("FAIL step_unlock: got %0b expected 0", io_locked); end
    for (int i = 0; i < 5; i++) begin
      good(relock_seq[i]);
      checks++;
      if (io_locked !== (i == 4)) begin
        errors++; $display("FAIL step_relock cycle %0d: got %0b expected %0b", i, io_locked, (i == 4));
      end
      checks++;
      if (io_error !== 1'b0) begin errors++; $display("FAIL step_single_pulse cycle %0d: got %0b expected 0", i, io_error); end
    end
    checks++; if (io_errorCount !== 8'd1) begin errors++; $display("FAIL step_errcnt_hold: got %0d expected 1", io_errorCount); end
  endtask

  task automatic test_flag();
    do_reset();
    relock(8'd7);
    drive(8'd7, 1'b1, 1'b0, 1'b0);
    checks++; if (io_error !== 1'b1) begin errors++; $display("FAIL flag_err_pulse: got %0b expected 1", io_error); end
    checks++; if (io_errorCount !== 8'd1) begin errors++; $display("FAIL flag_errcnt: got %0d expected 1", io_errorCount); end
    good(8'd7);
    relock(8'd7);
    checks++; if (io_locked !== 1'b1) begin errors++; $display("FAIL flag_relock: got %0b expected 1", io_locked); end
    drive(8'd7, 1'b1, 1'b1, 1'b0);
    checks++; if (io_error !== 1'b0) begin errors++; $display("FAIL flag_cond1_noerr: got %0b expected 0", io_error); end
    checks++; if (io_locked !== 1'b1) begin errors++; $display("FAIL flag_cond1_locked: got %0b expected 1", io_locked); end
    checks++; if (io_errorCount !== 8'd1) begin errors++; $display("FAIL flag_cond1_errcnt: got %0d expected 1", io_errorCount); end
  endtask

  task automatic test_saturate_clear();
    int pulses;
    pulses = 0;
    do_reset();
    relock(8'd0);
    for (int i = 0; i < 300; i++) begin
      drive(8'd0, 1'b0, 1'b0, 1'b0);
      if (io_error === 1'b1) pulses++;
      if (i == 254) begin
        checks++;
        if (io_errorCount !== 8'd255) begin errors++; $display("FAIL sat_reach: got %0d expected 255", io_errorCount); end
      end
      good(8'd0);
      relock(8'd0);
    end
    checks++; if (pulses !== 300) begin errors++; $display("FAIL sat_pulses: got %0d expected 300", pulses); end
    checks++; if (io_errorCount !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d expected 255", io_errorCount); end
    drive(8'd0, 1'b0, 1'b0, 1'b1);
    checks++; if (io_errorCount !== 8'd0) begin errors++; $display("FAIL clear_wins: got %0d expected 0", io_errorCount); end
    checks++; if (io_error !== 1'b1) begin errors++; $display("FAIL clear_pulse: got %0b expected 1", io_error); end
    checks++; if (io_locked !== 1'b0) begin errors++; $display("FAIL clear_fsm: got %0b expected 0", io_locked); end
  endtask

  task automatic test_reset_in_fault();
    do_reset();
    relock(8'd5);
    good(8'd9);
    checks++; if (io_error !== 1'b1) begin errors++; $display("FAIL rf_enter_fault: got %0b expected 1", io_error); end
    reset = 1'b1;
    #1;
    checks++; if (io_errorCount !== 8'd0) begin errors++; $display("FAIL rf_async_errcnt: got %0d expected 0", io_errorCount); end
    @(posedge clk);
    #1;
    checks++;
    if ({io_locked, io_error, io_errorCount, io_wrapCount} !== 18'd0) begin
      errors++; $display("FAIL rf_outputs: got %0b/%0b/%0d/%0d expected 0/0/0/0", io_locked, io_error, io_errorCount, io_wrapCount);
    end
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      good(8'd9);
      checks++;
      if (io_locked !== (i == 4)) begin
        errors++; $display("FAIL rf_relock sample %0d: got %0b expected %0b", i, io_locked, (i == 4));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    io_state = 8'd0; io_flag = 1'b1; io_cond1 = 1'b0; io_clear = 1'b0;
    #1;
    test_reset();
    test_lock();
    test_wrap();
    test_step_error();
    test_flag();
    test_saturate_clear();
    test_reset_in_fault();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
